// File: rtl/sram_port_arbiter.sv
// Two-port valid/ready arbiter and SETUP/STROBE/HOLD sequencer for a 2k x 8 asynchronous SRAM.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module sram_port_arbiter #(
  parameter int STROBE_CYCLES = 2,
  parameter int ADDR_W        = 11,
  parameter int DATA_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic              req0_write,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        wr_reg;
  logic        port_reg;
  logic        sel1;
  logic        grant_ok;
  logic        xfer;
  logic        capture;
  logic [1:0]  rsp_valid;
  logic [DATA_W-1:0] rdata_reg [2];

`ifdef SRAM_ARB_RR_EN
  // last_reg = 1 means port 1 was granted last, so port 0 wins a tie.
  logic last_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_reg <= 1'b1;
    end else if (xfer) begin
      last_reg <= sel1;
    end
  end

  assign sel1 = req1_valid && (!req0_valid || !last_reg);
`else
  assign sel1 = req1_valid && !req0_valid;
`endif

  // Ready is masked during reset so reset always wins over a transfer.
  assign grant_ok   = (state_reg == IDLE) && !reset;
  assign req0_ready = grant_ok && req0_valid && !sel1;
  assign req1_ready = grant_ok && sel1;
  assign xfer       = req0_ready || req1_ready;

  assign capture = (state_reg == STROBE) && (cnt_reg == 4'd0) && !wr_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE:   if (xfer) state_next = SETUP;
      SETUP: begin
        state_next = STROBE;
        cnt_next   = CNT_LOAD;
      end
      STROBE: begin
        if (cnt_reg == 4'd0) state_next = HOLD;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Enables are registered from the next state so the pins change only at clock edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      wr_reg    <= 1'b0;
      port_reg  <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
      sram_ce_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sram_ce_n <= (state_next == IDLE);
      sram_we_n <= !((state_next == STROBE) && wr_reg);
      sram_oe_n <= !((state_next == STROBE) && !wr_reg);
      if (xfer) begin
        wr_reg    <= sel1 ? req1_write : req0_write;
        port_reg  <= sel1;
        sram_addr <= sel1 ? req1_addr  : req0_addr;
        sram_din  <= sel1 ? req1_wdata : req0_wdata;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    always_ff @(posedge clk) begin
      if (reset) begin
        rdata_reg[gi] <= '0;
      end else if (capture && (port_reg == 1'(gi))) begin
        rdata_reg[gi] <= sram_dout;
      end
    end
    assign rsp_valid[gi] = (state_reg == HOLD) && (port_reg == 1'(gi));
  end

  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_rdata = rdata_reg[0];
  assign rsp1_rdata = rdata_reg[1];

endmodule
